// File: rtl/ls_ctrl_pkg.sv
// Shared widths, opcode encodings and FSM states for the load/store controller.
package ls_ctrl_pkg;

  localparam int unsigned OP_WIDTH   = 4;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ROB_WIDTH  = 4;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned LEN_WIDTH  = 3;

  localparam logic [OP_WIDTH-1:0] OP_LB  = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_LH  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_LW  = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_LBU = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_LHU = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_SB  = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_SH  = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_SW  = OP_WIDTH'(7);

  typedef enum logic [1:0] {
    LS_IDLE = 2'd0,
    LS_BUSY = 2'd1,
    LS_DROP = 2'd2
  } ls_state_e;

  function automatic logic is_store(input logic [OP_WIDTH-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/ls_ctrl_if.sv
// LSB issue, memory-controller and CDB signals of the load/store controller.
interface ls_ctrl_if;
  import ls_ctrl_pkg::*;

  logic                  rdy_lsb_in;
  logic [OP_WIDTH-1:0]   opcode_lsb_in;
  logic [DATA_WIDTH-1:0] vj_lsb_in;
  logic [DATA_WIDTH-1:0] vk_lsb_in;
  logic [DATA_WIDTH-1:0] imm_lsb_in;
  logic [ROB_WIDTH-1:0]  rob_id_lsb_in;
  logic                  idle_lsb_out;

  logic                  req_mc_out;
  logic                  wr_mc_out;
  logic [ADDR_WIDTH-1:0] addr_mc_out;
  logic [LEN_WIDTH-1:0]  len_mc_out;
  logic [31:0]           data_mc_out;
  logic                  done_mc_in;
  logic [31:0]           data_mc_in;

  logic                  refresh_rob_cdb_in;
  logic                  rdy_ls_cdb_out;
  logic [DATA_WIDTH-1:0] result_ls_cdb_out;
  logic [ROB_WIDTH-1:0]  rob_id_ls_cdb_out;

  modport slave (
    input  rdy_lsb_in, opcode_lsb_in, vj_lsb_in, vk_lsb_in, imm_lsb_in, rob_id_lsb_in,
    output idle_lsb_out,
    output req_mc_out, wr_mc_out, addr_mc_out, len_mc_out, data_mc_out,
    input  done_mc_in, data_mc_in,
    input  refresh_rob_cdb_in,
    output rdy_ls_cdb_out, result_ls_cdb_out, rob_id_ls_cdb_out
  );

  modport master (
    output rdy_lsb_in, opcode_lsb_in, vj_lsb_in, vk_lsb_in, imm_lsb_in, rob_id_lsb_in,
    input  idle_lsb_out,
    input  req_mc_out, wr_mc_out, addr_mc_out, len_mc_out, data_mc_out,
    output done_mc_in, data_mc_in,
    output refresh_rob_cdb_in,
    input  rdy_ls_cdb_out, result_ls_cdb_out, rob_id_ls_cdb_out
  );
endinterface

// File: rtl/ls_ctrl_extend.sv
// Size decode and extension: sign/zero-extends load data, and for stores
// zero-extends (masks) the write data; also yields the byte count.
module ls_ctrl_extend
  import ls_ctrl_pkg::*;
(
  input  logic [OP_WIDTH-1:0]  i_op,
  input  logic [31:0]          i_data,
  output logic [31:0]          o_result,
  output logic [LEN_WIDTH-1:0] o_len
);

  always_comb begin
    o_result = i_data;
    o_len    = LEN_WIDTH'(4);
    case (i_op)
      OP_LB: begin
        o_result = {{24{i_data[7]}}, i_data[7:0]};
        o_len    = LEN_WIDTH'(1);
      end
      OP_LBU, OP_SB: begin
        o_result = {24'd0, i_data[7:0]};
        o_len    = LEN_WIDTH'(1);
      end
      OP_LH: begin
        o_result = {{16{i_data[15]}}, i_data[15:0]};
        o_len    = LEN_WIDTH'(2);
      end
      OP_LHU, OP_SH: begin
        o_result = {16'd0, i_data[15:0]};
        o_len    = LEN_WIDTH'(2);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ls_ctrl.sv
// Load/store controller: issues one sized memory access at a time and
// broadcasts the (extended) result on the load/store CDB.
module ls_ctrl
  import ls_ctrl_pkg::*;
(
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  ls_ctrl_if.slave bus
);

  ls_state_e             r_state, w_state_nxt;
  logic [OP_WIDTH-1:0]   r_op, w_op_nxt;
  logic [ROB_WIDTH-1:0]  r_rob, w_rob_nxt;
  logic                  r_req, w_req_nxt;
  logic                  r_wr, w_wr_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [LEN_WIDTH-1:0]  r_len, w_len_nxt;
  logic [31:0]           r_data, w_data_nxt;
  logic                  r_cdb_rdy, w_cdb_rdy_nxt;
  logic [DATA_WIDTH-1:0] r_cdb_res, w_cdb_res_nxt;
  logic [ROB_WIDTH-1:0]  r_cdb_rob, w_cdb_rob_nxt;

  logic                  w_idle;
  logic [OP_WIDTH-1:0]   w_ext_op;
  logic [31:0]           w_ext_in;
  logic [31:0]           w_ext_res;
  logic [LEN_WIDTH-1:0]  w_ext_len;

  assign w_idle = (r_state == LS_IDLE);

  // One extender serves both directions: store-data masking while idle, load extension while busy.
  assign w_ext_op = w_idle ? bus.opcode_lsb_in : r_op;
  assign w_ext_in = w_idle ? bus.vk_lsb_in : bus.data_mc_in;

  ls_ctrl_extend u_ext (
    .i_op     (w_ext_op),
    .i_data   (w_ext_in),
    .o_result (w_ext_res),
    .o_len    (w_ext_len)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_op_nxt      = r_op;
    w_rob_nxt     = r_rob;
    w_req_nxt     = r_req;
    w_wr_nxt      = r_wr;
    w_addr_nxt    = r_addr;
    w_len_nxt     = r_len;
    w_data_nxt    = r_data;
    w_cdb_rdy_nxt = 1'b0;
    w_cdb_res_nxt = r_cdb_res;
    w_cdb_rob_nxt = r_cdb_rob;
    case (r_state)
      LS_IDLE: begin
        if (bus.rdy_lsb_in && !bus.refresh_rob_cdb_in) begin
          w_op_nxt    = bus.opcode_lsb_in;
          w_rob_nxt   = bus.rob_id_lsb_in;
          w_addr_nxt  = ADDR_WIDTH'(bus.vj_lsb_in + bus.imm_lsb_in);
          w_len_nxt   = w_ext_len;
          w_data_nxt  = w_ext_res;
          w_wr_nxt    = is_store(bus.opcode_lsb_in);
          w_req_nxt   = 1'b1;
          w_state_nxt = LS_BUSY;
        end
      end
      LS_BUSY: begin
        if (bus.done_mc_in) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = LS_IDLE;
          // A completion landing in the flush cycle is never broadcast.
          if (!bus.refresh_rob_cdb_in) begin
            w_cdb_rdy_nxt = 1'b1;
            w_cdb_rob_nxt = r_rob;
            w_cdb_res_nxt = is_store(r_op) ? '0 : DATA_WIDTH'(w_ext_res);
          end
        end else if (bus.refresh_rob_cdb_in && !is_store(r_op)) begin
          w_state_nxt = LS_DROP;
        end
      end
      LS_DROP: begin
        if (bus.done_mc_in) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = LS_IDLE;
        end
      end
      default: w_state_nxt = LS_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= LS_IDLE;
      r_op      <= '0;
      r_rob     <= '0;
      r_req     <= 1'b0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_len     <= '0;
      r_data    <= '0;
      r_cdb_rdy <= 1'b0;
      r_cdb_res <= '0;
      r_cdb_rob <= '0;
    end else if (rdy_in) begin
      r_state   <= w_state_nxt;
      r_op      <= w_op_nxt;
      r_rob     <= w_rob_nxt;
      r_req     <= w_req_nxt;
      r_wr      <= w_wr_nxt;
      r_addr    <= w_addr_nxt;
      r_len     <= w_len_nxt;
      r_data    <= w_data_nxt;
      r_cdb_rdy <= w_cdb_rdy_nxt;
      r_cdb_res <= w_cdb_res_nxt;
      r_cdb_rob <= w_cdb_rob_nxt;
    end
  end

  assign bus.idle_lsb_out      = w_idle;
  assign bus.req_mc_out        = r_req;
  assign bus.wr_mc_out         = r_wr;
  assign bus.addr_mc_out       = r_addr;
  assign bus.len_mc_out        = r_len;
  assign bus.data_mc_out       = r_data;
  assign bus.rdy_ls_cdb_out    = r_cdb_rdy;
  assign bus.result_ls_cdb_out = r_cdb_res;
  assign bus.rob_id_ls_cdb_out = r_cdb_rob;

endmodule

// File: tb/tb_ls_ctrl.sv
// Directed self-checking bench for ls_ctrl with hand-computed expectations.
module tb_ls_ctrl;
  import ls_ctrl_pkg::*;

  logic clk;
  logic rst;
  logic rdy;
  int   n_checks;
  int   n_errors;

  ls_ctrl_if u_if ();

  ls_ctrl u_dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [OP_WIDTH-1:0] op, input logic [31:0] vj,
                       input logic [31:0] imm, input logic [31:0] vk,
                       input logic [ROB_WIDTH-1:0] rob);
    u_if.rdy_lsb_in    = 1'b1;
    u_if.opcode_lsb_in = op;
    u_if.vj_lsb_in     = vj;
    u_if.imm_lsb_in    = imm;
    u_if.vk_lsb_in     = vk;
    u_if.rob_id_lsb_in = rob;
    tick();
    u_if.rdy_lsb_in    = 1'b0;
  endtask

  // Full load: accept, wait, complete, then check the one-cycle broadcast.
  task automatic do_load(input string tag, input logic [OP_WIDTH-1:0] op,
                         input logic [31:0] vj, input logic [31:0] imm,
                         input logic [ROB_WIDTH-1:0] rob, input int waits,
                         input logic [31:0] mdata, input logic [31:0] exp_addr,
                         input logic [2:0] exp_len, input logic [31:0] exp_res);
    issue(op, vj, imm, 32'h0, rob);
    chk({tag, " req"}, 32'(u_if.req_mc_out), 32'd1);
    chk({tag, " wr"}, 32'(u_if.wr_mc_out), 32'd0);
    chk({tag, " addr"}, u_if.addr_mc_out, exp_addr);
    chk({tag, " len"}, 32'(u_if.len_mc_out), 32'(exp_len));
    chk({tag, " busy"}, 32'(u_if.idle_lsb_out), 32'd0);
    for (int i = 0; i < waits; i++) begin
      tick();
      chk({tag, " req held"}, 32'(u_if.req_mc_out), 32'd1);
    end
    u_if.done_mc_in = 1'b1;
    u_if.data_mc_in = mdata;
    tick();
    u_if.done_mc_in = 1'b0;
    u_if.data_mc_in = 32'h0;
    chk({tag, " cdb rdy"}, 32'(u_if.rdy_ls_cdb_out), 32'd1);
    chk({tag, " cdb res"}, u_if.result_ls_cdb_out, exp_res);
    chk({tag, " cdb rob"}, 32'(u_if.rob_id_ls_cdb_out), 32'(rob));
    chk({tag, " req off"}, 32'(u_if.req_mc_out), 32'd0);
    chk({tag, " idle"}, 32'(u_if.idle_lsb_out), 32'd1);
    tick();
    chk({tag, " cdb pulse"}, 32'(u_if.rdy_ls_cdb_out), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    rdy = 1'b1;
    u_if.rdy_lsb_in         = 1'b0;
    u_if.opcode_lsb_in      = '0;
    u_if.vj_lsb_in          = '0;
    u_if.vk_lsb_in          = '0;
    u_if.imm_lsb_in         = '0;
    u_if.rob_id_lsb_in      = '0;
    u_if.done_mc_in         = 1'b0;
    u_if.data_mc_in         = '0;
    u_if.refresh_rob_cdb_in = 1'b0;
    #1 rst = 1'b1;
    tick();
    tick();
    chk("rst idle", 32'(u_if.idle_lsb_out), 32'd1);
    chk("rst req", 32'(u_if.req_mc_out), 32'd0);
    chk("rst wr", 32'(u_if.wr_mc_out), 32'd0);
    chk("rst cdb", 32'(u_if.rdy_ls_cdb_out), 32'd0);
    chk("rst addr", u_if.addr_mc_out, 32'd0);
    chk("rst len", 32'(u_if.len_mc_out), 32'd0);
    chk("rst res", u_if.result_ls_cdb_out, 32'd0);
    rst = 1'b0;
    tick();

    do_load("lw",  OP_LW,  32'h1000, 32'h10, 4'd3, 2, 32'hDEADBEEF, 32'h1010, 3'd4, 32'hDEADBEEF);
    do_load("lb",  OP_LB,  32'h40, 32'h1, 4'd1, 0, 32'h00000080, 32'h41, 3'd1, 32'hFFFFFF80);
    do_load("lbu", OP_LBU, 32'h40, 32'h2, 4'd2, 1, 32'h00000080, 32'h42, 3'd1, 32'h00000080);
    do_load("lh",  OP_LH,  32'h80, 32'h4, 4'd4, 1, 32'h00008001, 32'h84, 3'd2, 32'hFFFF8001);
    do_load("lhu", OP_LHU, 32'hFFFFFFFE, 32'h4, 4'd5, 0, 32'h12348001, 32'h2, 3'd2, 32'h00008001);

    // SH with negative offset
    issue(OP_SH, 32'h20, 32'hFFFFFFFE, 32'h12345678, 4'd5);
    chk("sh req", 32'(u_if.req_mc_out), 32'd1);
    chk("sh wr", 32'(u_if.wr_mc_out), 32'd1);
    chk("sh addr", u_if.addr_mc_out, 32'h1E);
    chk("sh len", 32'(u_if.len_mc_out), 32'd2);
    chk("sh data", u_if.data_mc_out, 32'h5678);
    u_if.done_mc_in = 1'b1;
    tick();
    u_if.done_mc_in = 1'b0;
    chk("sh cdb rdy", 32'(u_if.rdy_ls_cdb_out), 32'd1);
    chk("sh cdb res", u_if.result_ls_cdb_out, 32'd0);
    chk("sh cdb rob", 32'(u_if.rob_id_ls_cdb_out), 32'd5);
    tick();

    // SB masks to one byte
    issue(OP_SB, 32'h100, 32'h3, 32'hCAFEBABE, 4'd6);
    chk("sb len", 32'(u_if.len_mc_out), 32'd1);
    chk("sb data", u_if.data_mc_out, 32'hBE);
    u_if.done_mc_in = 1'b1;
    tick();
    u_if.done_mc_in = 1'b0;
    tick();

    // Load flushed two cycles into the request: held until done, no broadcast
    issue(OP_LW, 32'h200, 32'h0, 32'h0, 4'd7);
    tick();
    u_if.refresh_rob_cdb_in = 1'b1;
    tick();
    u_if.refresh_rob_cdb_in = 1'b0;
    chk("flush req held", 32'(u_if.req_mc_out), 32'd1);
    chk("flush not idle", 32'(u_if.idle_lsb_out), 32'd0);
    tick();
    tick();
    u_if.done_mc_in = 1'b1;
    u_if.data_mc_in = 32'h11111111;
    tick();
    u_if.done_mc_in = 1'b0;
    chk("flush req off", 32'(u_if.req_mc_out), 32'd0);
    chk("flush no cdb", 32'(u_if.rdy_ls_cdb_out), 32'd0);
    chk("flush idle", 32'(u_if.idle_lsb_out), 32'd1);
    tick();
    chk("flush no cdb2", 32'(u_if.rdy_ls_cdb_out), 32'd0);

    // Load with refresh and done in the same cycle
    issue(OP_LB, 32'h0, 32'h5, 32'h0, 4'd8);
    u_if.refresh_rob_cdb_in = 1'b1;
    u_if.done_mc_in = 1'b1;
    tick();
    u_if.refresh_rob_cdb_in = 1'b0;
    u_if.done_mc_in = 1'b0;
    chk("ld same idle", 32'(u_if.idle_lsb_out), 32'd1);
    chk("ld same no cdb", 32'(u_if.rdy_ls_cdb_out), 32'd0);

    // Store plus refresh mid-flight: completes and broadcasts
    issue(OP_SW, 32'h300, 32'h4, 32'hA5A5A5A5, 4'd9);
    u_if.refresh_rob_cdb_in = 1'b1;
    tick();
    u_if.refresh_rob_cdb_in = 1'b0;
    chk("st ref req", 32'(u_if.req_mc_out), 32'd1);
    chk("st ref busy", 32'(u_if.idle_lsb_out), 32'd0);
    chk("st ref data", u_if.data_mc_out, 32'hA5A5A5A5);
    u_if.done_mc_in = 1'b1;
    tick();
    u_if.done_mc_in = 1'b0;
    chk("st ref cdb", 32'(u_if.rdy_ls_cdb_out), 32'd1);
    chk("st ref rob", 32'(u_if.rob_id_ls_cdb_out), 32'd9);
    // Refresh in the broadcast cycle does not cancel it; same-cycle issue in IDLE is dropped
    u_if.refresh_rob_cdb_in = 1'b1;
    issue(OP_LW, 32'h0, 32'h0, 32'h0, 4'd10);
    u_if.refresh_rob_cdb_in = 1'b0;
    chk("drop issue idle", 32'(u_if.idle_lsb_out), 32'd1);
    chk("drop issue req", 32'(u_if.req_mc_out), 32'd0);

    // Store done in the refresh cycle: write done, broadcast suppressed
    issue(OP_SW, 32'h400, 32'h0, 32'h1, 4'd11);
    u_if.refresh_rob_cdb_in = 1'b1;
    u_if.done_mc_in = 1'b1;
    tick();
    u_if.refresh_rob_cdb_in = 1'b0;
    u_if.done_mc_in = 1'b0;
    chk("st same no cdb", 32'(u_if.rdy_ls_cdb_out), 32'd0);
    chk("st same idle", 32'(u_if.idle_lsb_out), 32'd1);

    // rdy_in low freezes the CDB pulse and blocks acceptance
    issue(OP_LBU, 32'h10, 32'h0, 32'h0, 4'd12);
    u_if.done_mc_in = 1'b1;
    u_if.data_mc_in = 32'hFF;
    tick();
    u_if.done_mc_in = 1'b0;
    rdy = 1'b0;
    u_if.rdy_lsb_in = 1'b1;
    tick();
    tick();
    chk("frz cdb", 32'(u_if.rdy_ls_cdb_out), 32'd1);
    chk("frz res", u_if.result_ls_cdb_out, 32'hFF);
    chk("frz req", 32'(u_if.req_mc_out), 32'd0);
    u_if.rdy_lsb_in = 1'b0;
    rdy = 1'b1;
    tick();
    chk("unfrz cdb", 32'(u_if.rdy_ls_cdb_out), 32'd0);

    // Async reset mid-BUSY clears outputs without a clock edge
    issue(OP_SW, 32'h500, 32'h8, 32'h77, 4'd13);
    chk("pre rst req", 32'(u_if.req_mc_out), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst req", 32'(u_if.req_mc_out), 32'd0);
    chk("arst wr", 32'(u_if.wr_mc_out), 32'd0);
    chk("arst addr", u_if.addr_mc_out, 32'd0);
    chk("arst idle", 32'(u_if.idle_lsb_out), 32'd1);
    rst = 1'b0;
    tick();
    do_load("post", OP_LW, 32'h20, 32'h4, 4'd14, 1, 32'h0BADF00D, 32'h24, 3'd4, 32'h0BADF00D);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
